parser_conf_arbiter: RTL
========================

Name: parser_conf_arbiter

Overview:
- Shares the parser's single rule-configuration bus (wren/rden/addr/wdata in, rdata_valid/rdata back) between REQ_NUM requesters, for example a host CSR bridge and a bulk rule loader.
- Uses round-robin grant with burst lock. A granted requester keeps the bus until it issues a beat with last set.
- Routes read data back to the requester that issued the read.
- Sits between the requesters and the parser top's rule ports.

Parameters:
- REQ_NUM, 2, number of requesters (2..8).
- ID_WIDTH, $clog2(REQ_NUM), grant index width.
- RD_TIMEOUT, 64, read-response watchdog limit in cycles (used only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_req_valid  in  REQ_NUM  per-requester beat valid.
- i_req_write  in  REQ_NUM  1 = write beat, 0 = read beat.
- i_req_last  in  REQ_NUM  beat ends the burst and releases the grant.
- i_req_addr  in  REQ_NUM*32  packed addresses; requester k uses bits [k*32+:32].
- i_req_wdata  in  REQ_NUM*32  packed write data, same packing.
- o_req_ready  out  REQ_NUM  beat accepted when valid&ready.
- o_rsp_valid  out  REQ_NUM  one-cycle read-response pulse to the owning requester.
- o_rsp_rdata  out  32  read data, shared by all requesters.
- o_rsp_err  out  1  response error flag (timeout).
- o_rule_wren  out  1  write strobe to the parser.
- o_rule_rden  out  1  read strobe to the parser.
- o_rule_addr  out  32  address to the parser.
- o_rule_wdata  out  32  write data to the parser.
- i_rule_rdata_valid  in  1  read data valid from the parser.
- i_rule_rdata  in  32  read data from the parser.
- o_busy  out  1  high in every state except IDLE.
- o_grant_id  out  ID_WIDTH  current or last grantee.

Behaviour:
- Clocking and reset (already decided): one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset state:
  - state = IDLE, rr_ptr = 0.
  - All outputs 0: strobes, addr, wdata, o_rsp_*, o_req_ready, o_busy, o_grant_id.
- Reset mid-operation: any in-flight read is dropped; no o_rsp_valid is issued for it.
- FSM states: IDLE, GRANT, RD_WAIT.
- IDLE:
  - If any i_req_valid is set, grant the first set bit searching upward from rr_ptr with wrap-around.
  - Register o_grant_id and go to GRANT next cycle.
  - Granting costs exactly 1 cycle; o_req_ready stays low in IDLE.
- GRANT:
  - o_req_ready[g] = 1 (combinational from state and g). All other ready bits are 0.
  - On handshake, next cycle o_rule_addr/o_rule_wdata are registered from requester g, and exactly one of o_rule_wren or o_rule_rden pulses for 1 cycle.
  - Write beat: stay in GRANT. If last is set, go to IDLE and set rr_ptr = g+1 mod REQ_NUM.
  - Read beat: go to RD_WAIT. The last flag is captured.
  - Bus latency is 1 cycle from handshake to strobe. Back-to-back writes run at 1 beat per cycle.
- RD_WAIT:
  - o_req_ready = 0.
  - i_rule_rdata_valid is accepted in any RD_WAIT cycle, including the same cycle o_rule_rden is high (the parser answers combinationally).
  - On accept, next cycle: o_rsp_valid[g] = 1 for 1 cycle, o_rsp_rdata = i_rule_rdata, o_rsp_err = 0.
  - After the response, return to GRANT, or to IDLE (with rr_ptr update) if the captured last was set.
- i_rule_rdata_valid outside RD_WAIT is ignored.
- Dropping i_req_valid mid-burst is legal: the grant is held until a last beat.
- addr and wdata keep their last values when no strobe is active.
- Only one read is outstanding at a time.

Optional Feature:
- Macro: PARSER_CONF_RD_TIMEOUT_EN.
- Defined:
  - A counter clears on RD_WAIT entry and increments each RD_WAIT cycle without rdata_valid.
  - When it reaches RD_TIMEOUT, issue o_rsp_valid[g] with o_rsp_rdata = 32'hDEAD_BEEF and o_rsp_err = 1, then leave RD_WAIT as for a normal response.
- Not defined:
  - No counter; RD_WAIT waits indefinitely.
  - o_rsp_err is tied to 0.

Test Plan:
1. Reset, then requester 0 writes a 3-beat burst (addr 0x10, 0x14, 0x18; last on the 3rd beat) -> wren pulses on 3 consecutive cycles starting 2 cycles after valid, with matching addr/wdata; o_busy drops after the burst; rr_ptr = 1.
2. Requesters 0 and 1 both hold single-beat writes with last set, continuously -> grants alternate 0,1,0,1; no requester is granted twice in a row.
3. Requester 1 reads addr 0x20 while the parser returns rdata_valid the same cycle as rden with data 0x0000_00AB -> o_rsp_valid[1] pulses 1 cycle later with rdata 0xAB; o_rsp_valid[0] stays 0.
4. Requester 0 burst of write, then read with last, while requester 1 is requesting -> requester 1 sees ready = 0 until requester 0's read response has completed; requester 1 is then granted.
5. Assert i_rst while in RD_WAIT, then release -> all outputs 0, state IDLE; a late rdata_valid produces no rsp.
6. With PARSER_CONF_RD_TIMEOUT_EN and RD_TIMEOUT = 8, a read gets no response -> after 8 RD_WAIT cycles, rsp_valid fires with rdata 0xDEADBEEF and err = 1, and the grant proceeds normally.

Source files
------------

// File: rtl/parser_conf_arbiter.sv
// parser_conf_arbiter: shares the parser rule-configuration bus between
// REQ_NUM requesters using round-robin grant with burst lock. Read data is
// returned to the requester that issued the read.
// Optional read watchdog: define PARSER_CONF_RD_TIMEOUT_EN.
module parser_conf_arbiter #(
  parameter int REQ_NUM    = 2,
  parameter int ID_WIDTH   = $clog2(REQ_NUM),
  parameter int RD_TIMEOUT = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [REQ_NUM-1:0]      i_req_valid,
  input  logic [REQ_NUM-1:0]      i_req_write,
  input  logic [REQ_NUM-1:0]      i_req_last,
  input  logic [REQ_NUM*32-1:0]   i_req_addr,
  input  logic [REQ_NUM*32-1:0]   i_req_wdata,
  output logic [REQ_NUM-1:0]      o_req_ready,
  output logic [REQ_NUM-1:0]      o_rsp_valid,
  output logic [31:0]             o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic                    o_rule_wren,
  output logic                    o_rule_rden,
  output logic [31:0]             o_rule_addr,
  output logic [31:0]             o_rule_wdata,
  input  logic                    i_rule_rdata_valid,
  input  logic [31:0]             i_rule_rdata,
  output logic                    o_busy,
  output logic [ID_WIDTH-1:0]     o_grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_WIDTH-1:0] r_grant_id;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic                r_last;
  logic                r_wren;
  logic                r_rden;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [REQ_NUM-1:0]  r_rsp_valid;
  logic [31:0]         r_rsp_rdata;

  logic [REQ_NUM-1:0]  w_gnt_onehot;
  logic                w_sel_valid;
  logic                w_sel_write;
  logic                w_sel_last;
  logic [31:0]         w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic                w_found_hi;
  logic                w_found_lo;
  logic [ID_WIDTH-1:0] w_pick_hi;
  logic [ID_WIDTH-1:0] w_pick_lo;
  logic [ID_WIDTH-1:0] w_pick;
  logic [ID_WIDTH-1:0] w_next_ptr;
  logic                w_any;
  logic                w_hs;
  logic                w_rd_accept;
  logic                w_tmo;
  logic                w_release;

  // Select the granted requester's beat fields and build the grant one-hot
  always_comb begin
    w_gnt_onehot = '0;
    w_sel_valid  = 1'b0;
    w_sel_write  = 1'b0;
    w_sel_last   = 1'b0;
    w_sel_addr   = '0;
    w_sel_wdata  = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (ID_WIDTH'(k) == r_grant_id) begin
        w_gnt_onehot[k] = 1'b1;
        w_sel_valid     = i_req_valid[k];
        w_sel_write     = i_req_write[k];
        w_sel_last      = i_req_last[k];
        w_sel_addr      = i_req_addr[k*32 +: 32];
        w_sel_wdata     = i_req_wdata[k*32 +: 32];
      end
    end
  end

  // Round-robin pick: lowest valid at or above rr_ptr, else lowest valid overall
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (i_req_valid[k] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_pick_lo  = ID_WIDTH'(k);
      end
      if (i_req_valid[k] && (k >= 32'(r_rr_ptr)) && !w_found_hi) begin
        w_found_hi = 1'b1;
        w_pick_hi  = ID_WIDTH'(k);
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  assign w_any       = |i_req_valid;
  assign w_hs        = (r_state == GRANT) && w_sel_valid;
  assign w_rd_accept = (r_state == RD_WAIT) && i_rule_rdata_valid;
  assign w_next_ptr  = (r_grant_id == ID_WIDTH'(REQ_NUM - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef PARSER_CONF_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_rsp_err;

  // Watchdog: restart on RD_WAIT entry, count RD_WAIT cycles without data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (w_hs && !w_sel_write) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == RD_WAIT) && !i_rule_rdata_valid) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Counter reaches RD_TIMEOUT on the same edge the error response is registered
  assign w_tmo = (r_state == RD_WAIT) && !i_rule_rdata_valid &&
                 (r_tmo_cnt == TMO_W'(RD_TIMEOUT - 1));

  // Error flag accompanies each response pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_err <= 1'b0;
    end else if (w_rd_accept) begin
      r_rsp_err <= 1'b0;
    end else if (w_tmo) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign o_rsp_err = r_rsp_err;
`else
  assign w_tmo     = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  // Next-state logic; w_release marks the end of a burst
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = GRANT;
      end
      GRANT: begin
        if (w_hs) begin
          if (!w_sel_write) begin
            w_state_nxt = RD_WAIT;
          end else if (w_sel_last) begin
            w_state_nxt = IDLE;
            w_release   = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (w_rd_accept || w_tmo) begin
          if (r_last) begin
            w_state_nxt = IDLE;
            w_release   = 1'b1;
          end else begin
            w_state_nxt = GRANT;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant bookkeeping, bus strobes and read-response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_last      <= 1'b0;
      r_wren      <= 1'b0;
      r_rden      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_wren      <= 1'b0;
      r_rden      <= 1'b0;
      r_rsp_valid <= '0;
      if ((r_state == IDLE) && w_any) begin
        r_grant_id <= w_pick;
      end
      if (w_hs) begin
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_wren  <= w_sel_write;
        r_rden  <= !w_sel_write;
        if (!w_sel_write) r_last <= w_sel_last;
      end
      if (w_rd_accept) begin
        r_rsp_valid <= w_gnt_onehot;
        r_rsp_rdata <= i_rule_rdata;
      end else if (w_tmo) begin
        r_rsp_valid <= w_gnt_onehot;
        r_rsp_rdata <= 32'hDEAD_BEEF;
      end
      if (w_release) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign o_req_ready  = (r_state == GRANT) ? w_gnt_onehot : '0;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_rule_wren  = r_wren;
  assign o_rule_rden  = r_rden;
  assign o_rule_addr  = r_addr;
  assign o_rule_wdata = r_wdata;
  assign o_busy       = (r_state != IDLE);
  assign o_grant_id   = r_grant_id;

endmodule
